// File: rtl/prbs8_pkg.sv
// Shared definitions for the PRBS8 checker: history width, XNOR tap set and FSM encoding.
package prbs8_pkg;

    localparam int HIST_W = 8;

    // Taps {7,5,4,3} of the history register: x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [HIST_W-1:0] TAP_MASK = 8'b1011_1000;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs8_predict.sv
// Received-bit history shift register and XNOR predictor of the next expected bit.
module prbs8_predict
    import prbs8_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic [HIST_W-1:0] h,
    output logic              p
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h <= '0;
        end else if (bit_valid_i) begin
            h <= {h[HIST_W-2:0], bit_i};
        end
    end

    assign p = ~(^(h & TAP_MASK));

endmodule

// File: rtl/prbs8_checker.sv
// PRBS8 checker: fill / search / locked FSM with windowed loss-of-lock and a saturating error count.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int LOSS_ERRS = 8,
    parameter int WINDOW    = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o
);

    localparam int FILL_W = $clog2(HIST_W + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(LOSS_ERRS + 1);

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                err_d;
    logic [HIST_W-1:0]   h;
    logic                p;
    logic                match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    prbs8_predict u_predict (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .h           (h),
        .p           (p)
    );

    assign match = (bit_i == p);

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        run_d   = run_q;
        win_d   = win_q;
        werr_d  = werr_q;
        cnt_d   = err_count_o;
        err_d   = 1'b0;
        if (bit_valid_i) begin
            unique case (state_q)
                ST_FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_W'(HIST_W - 1)) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    // An all-ones history predicts 1 forever; never let it build a run.
                    if (match && (h != '1)) begin
                        run_d = run_q + 1'b1;
                    end else begin
                        run_d = '0;
                    end
                    if (run_d == RUN_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        err_d  = 1'b1;
                        cnt_d  = sat_inc(err_count_o);
                        werr_d = werr_q + 1'b1;
                    end
                    // The error on the last window bit is judged against the ending window.
                    if (werr_d == WERR_W'(LOSS_ERRS)) begin
                        state_d = ST_SEARCH;
                        run_d   = '0;
                    end else if (win_q == WIN_W'(WINDOW - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_FILL;
            fill_q      <= '0;
            run_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            err_count_o <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_o    <= (state_d == ST_LOCKED);
            err_o       <= err_d;
            err_count_o <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: generator stream with injected bit flips, checked against a bit-history model.
module tb_prbs8_checker;

    localparam int LOCK_CNT  = 16;
    localparam int LOSS_ERRS = 8;
    localparam int WINDOW    = 64;
    localparam int CNT_W     = 5;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam int M_FILL   = 0;
    localparam int M_SEARCH = 1;
    localparam int M_LOCKED = 2;

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b1;
    logic             bit_i       = 1'b0;
    logic             bit_valid_i = 1'b0;
    logic             clr_i       = 1'b0;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_count_o;

    prbs8_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_ERRS (LOSS_ERRS),
        .WINDOW    (WINDOW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .clr_i       (clr_i),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    bit gen_q[$];
    bit rx_q[$];
    int m_mode;
    int m_fill;
    int m_run;
    int m_lbits;
    int m_werr;
    int m_cnt;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next sequence bit from the bits seen 8, 6, 5 and 4 positions back.
    function automatic bit xnor_taps(input bit q[$]);
        int n;
        n = q.size();
        return ~(q[n-8] ^ q[n-6] ^ q[n-5] ^ q[n-4]);
    endfunction

    task automatic gen_reset();
        gen_q = {};
        repeat (8) gen_q.push_back(1'b0);
    endtask

    task automatic gen_next(output bit b);
        b = xnor_taps(gen_q);
        void'(gen_q.pop_front());
        gen_q.push_back(b);
    endtask

    task automatic model_reset();
        rx_q = {};
        repeat (8) rx_q.push_back(1'b0);
        m_mode  = M_FILL;
        m_fill  = 0;
        m_run   = 0;
        m_lbits = 0;
        m_werr  = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit match;
        bit ones;
        m_err = 1'b0;
        if (v) begin
            match = (b == xnor_taps(rx_q));
            ones  = 1'b1;
            foreach (rx_q[i]) if (!rx_q[i]) ones = 1'b0;
            case (m_mode)
                M_FILL: begin
                    m_fill++;
                    if (m_fill == 8) m_mode = M_SEARCH;
                end
                M_SEARCH: begin
                    m_run = (match && !ones) ? m_run + 1 : 0;
                    if (m_run == LOCK_CNT) begin
                        m_mode  = M_LOCKED;
                        m_lbits = 0;
                    end
                end
                default: begin
                    if ((m_lbits % WINDOW) == 0) m_werr = 0;
                    m_lbits++;
                    if (!match) begin
                        m_err = 1'b1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                        m_werr++;
                    end
                    if (m_werr == LOSS_ERRS) begin
                        m_mode = M_SEARCH;
                        m_run  = 0;
                    end
                end
            endcase
            void'(rx_q.pop_front());
            rx_q.push_back(b);
        end
        if (c) m_cnt = 0;
    endtask

    task automatic send_raw(input bit v, input bit b, input bit c);
        bit_valid_i = v;
        bit_i       = b;
        clr_i       = c;
        @(posedge clk_i);
        model_step(v, b, c);
        #1;
        chk("locked_o", 32'(locked_o), 32'(m_mode == M_LOCKED));
        chk("err_o", 32'(err_o), 32'(m_err));
        chk("err_count_o", 32'(err_count_o), 32'(m_cnt));
    endtask

    task automatic send(input bit v, input bit flip, input bit c);
        bit tx;
        if (v) gen_next(tx);
        else tx = 1'($urandom);
        send_raw(v, v ? (tx ^ flip) : tx, c);
    endtask

    task automatic do_reset(input bit reseed);
        bit_valid_i = 1'b0;
        clr_i       = 1'b0;
        rst_i       = 1'b0;
        #1;
        chk("rst locked_o", 32'(locked_o), 0);
        chk("rst err_o", 32'(err_o), 0);
        chk("rst err_count_o", 32'(err_count_o), 0);
        model_reset();
        if (reseed) gen_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic wait_lock(input string tag);
        for (int i = 0; i < 200 && m_mode != M_LOCKED; i++) send(1'b1, 1'b0, 1'b0);
        chk(tag, 32'(locked_o), 1);
    endtask

    initial begin
        int nv;
        int errs;
        bit v;
        bit flip;

        do_reset(1'b1);

        for (int i = 1; i <= 30; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 23) chk("prelock23", 32'(locked_o), 0);
            if (i == 24) chk("lock24", 32'(locked_o), 1);
        end
        chk("clean count", 32'(err_count_o), 0);

        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        chk("flip err_o", 32'(err_o), 1);
        chk("flip count", 32'(err_count_o), 1);
        repeat (20) send(1'b1, 1'b0, 1'b0);
        chk("flip keeps lock", 32'(locked_o), 1);

        for (int i = 0; i < 32; i++) send(1'b1, (i % 4) == 0, 1'b0);
        chk("burst loses lock", 32'(locked_o), 0);
        repeat (40) send(1'b1, 1'b0, 1'b0);
        chk("relock", 32'(locked_o), 1);

        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(3, 0) != 0);
            flip = ($urandom_range(39, 0) == 0);
            send(v, flip, $urandom_range(49, 0) == 0);
        end

        send(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4000 && m_cnt < CNT_MAX - 1; i++) begin
            flip = (m_mode == M_LOCKED) && ($urandom_range(9, 0) == 0);
            send(1'b1, flip, 1'b0);
        end
        chk("near saturation", 32'(err_count_o), CNT_MAX - 1);
        errs = 0;
        for (int i = 0; i < 400 && errs < 2; i++) begin
            flip = (m_mode == M_LOCKED) && ($urandom_range(9, 0) == 0);
            send(1'b1, flip, 1'b0);
            if (m_err) errs++;
        end
        chk("saturated", 32'(err_count_o), CNT_MAX);

        wait_lock("lock before clr");
        send(1'b1, 1'b1, 1'b1);
        chk("clr vs err err_o", 32'(err_o), 1);
        chk("clr vs err count", 32'(err_count_o), 0);
        repeat (20) send(1'b1, 1'b0, 1'b0);

        wait_lock("lock before reset");
        #2;
        do_reset(1'b0);
        nv = 0;
        for (int i = 0; i < 90; i++) begin
            v = ((i % 3) == 0);
            send(v, 1'b0, 1'b0);
            if (v) nv++;
            if (v && nv == 23) chk("gapped prelock", 32'(locked_o), 0);
            if (v && nv == 24) chk("gapped lock", 32'(locked_o), 1);
        end

        do_reset(1'b1);
        for (int i = 0; i < 200; i++) begin
            send_raw(1'b1, 1'b1, 1'b0);
            chk("ones never lock", 32'(locked_o), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
